// File: rtl/buffered_console.sv
// buffered_console
//   Byte console between a CPU-side strobe interface and a host-side
//   valid/ready interface, with one FIFO in each direction.
//
//   Parameters
//     DATA_WIDTH   width of every data path
//     RX_AW        log2 of the RX FIFO depth (host -> CPU)
//     TX_AW        log2 of the TX FIFO depth (CPU -> host)
//     PATTERN_MODE 1 replaces the RX side with a repeating pattern source
//     PATTERN_BASE first pattern value
//     PATTERN_LEN  pattern period (1 .. 2^DATA_WIDTH)
//
//   Ports
//     CLK, RESET           clock, synchronous active-high reset
//     IN, WR, RDY          CPU write byte / strobe / TX FIFO has room
//     OUT, RDA, ACK        CPU read byte / byte valid / byte consumed
//     RX_DATA/VALID/READY  host push port (into RX FIFO)
//     TX_DATA/VALID/READY  host pop port (out of TX FIFO)
//     RX_LEVEL, TX_LEVEL   FIFO occupancies
//     OVF, CLR_OVF         sticky "CPU write dropped" flag and its clear
//
//   buffered_console_fifo
//     First-word-fall-through FIFO. Pushes are refused while full and pops
//     are ignored while empty, so callers can drive raw strobes.
//     Ports: CLK, RESET, i_data/i_push/o_ready (write side),
//            o_data/o_valid/i_pop (read side), o_level (occupancy).

module buffered_console_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [DW-1:0] i_data,
    input  logic          i_push,
    output logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    input  logic          i_pop,
    output logic [AW:0]   o_level
);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    assign o_ready = (r_level != DEPTH);
    assign o_valid = (r_level != '0);
    assign w_push  = i_push && o_ready;
    assign w_pop   = i_pop && o_valid;
    // Data reads as zero while empty so stale storage never leaks out.
    assign o_data  = o_valid ? r_mem[r_rptr] : '0;
    assign o_level = r_level;

    // Storage is not reset; the write is suppressed during reset so a
    // discarded push cannot disturb anything visible afterwards.
    always_ff @(posedge CLK) begin
        if (w_push && !RESET)
            r_mem[r_wptr] <= i_data;
    end

    // Pointers wrap naturally at the depth; level only moves when exactly
    // one of push/pop happens, so a simultaneous pair leaves it unchanged.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)
                r_level <= r_level + (AW+1)'(1);
            else if (w_pop && !w_push)
                r_level <= r_level - (AW+1)'(1);
        end
    end
endmodule

module buffered_console #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    RX_AW        = 4,
    parameter int                    TX_AW        = 4,
    parameter int                    PATTERN_MODE = 0,
    parameter logic [DATA_WIDTH-1:0] PATTERN_BASE = DATA_WIDTH'(8'h41),
    parameter int                    PATTERN_LEN  = 26
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic                  WR,
    output logic                  RDY,
    output logic [DATA_WIDTH-1:0] OUT,
    output logic                  RDA,
    input  logic                  ACK,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  RX_VALID,
    output logic                  RX_READY,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_VALID,
    input  logic                  TX_READY,
    output logic [RX_AW:0]        RX_LEVEL,
    output logic [TX_AW:0]        TX_LEVEL,
    output logic                  OVF,
    input  logic                  CLR_OVF
);
    logic r_ovf;

    buffered_console_fifo #(.DW(DATA_WIDTH), .AW(TX_AW)) u_txFifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_data  (IN),
        .i_push  (WR),
        .o_ready (RDY),
        .o_data  (TX_DATA),
        .o_valid (TX_VALID),
        .i_pop   (TX_READY),
        .o_level (TX_LEVEL)
    );

    // A write attempted while the TX FIFO is full is lost; remember that.
    // Setting takes priority over a clear in the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET)
            r_ovf <= 1'b0;
        else if (WR && !RDY)
            r_ovf <= 1'b1;
        else if (CLR_OVF)
            r_ovf <= 1'b0;
    end

    assign OVF = r_ovf;

    generate
        if (PATTERN_MODE != 0) begin : g_pattern
            localparam logic [DATA_WIDTH-1:0] PCNT_LAST = DATA_WIDTH'(PATTERN_LEN - 1);
            logic [DATA_WIDTH-1:0] r_pcnt;

            // The pattern source always has a byte ready, so every ACK
            // consumes one and advances the counter around the period.
            always_ff @(posedge CLK) begin
                if (RESET)
                    r_pcnt <= '0;
                else if (ACK)
                    r_pcnt <= (r_pcnt == PCNT_LAST) ? '0 : r_pcnt + DATA_WIDTH'(1);
            end

            assign OUT      = PATTERN_BASE + r_pcnt;
            assign RDA      = 1'b1;
            assign RX_READY = 1'b0;
            assign RX_LEVEL = '0;
        end else begin : g_rxFifo
            buffered_console_fifo #(.DW(DATA_WIDTH), .AW(RX_AW)) u_rxFifo (
                .CLK     (CLK),
                .RESET   (RESET),
                .i_data  (RX_DATA),
                .i_push  (RX_VALID),
                .o_ready (RX_READY),
                .o_data  (OUT),
                .o_valid (RDA),
                .i_pop   (ACK),
                .o_level (RX_LEVEL)
            );
        end
    endgenerate
endmodule

// File: tb/tb_buffered_console.sv
// tb_buffered_console
//   Drives a normal-mode and a pattern-mode buffered_console with the same
//   inputs and compares both against a queue-based reference model.

module tb_buffered_console;
    logic       CLK;
    logic       RESET;
    logic [7:0] IN;
    logic       WR;
    logic       ACK;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       TX_READY;
    logic       CLR_OVF;

    logic       RDY, RDA, RX_READY, TX_VALID, OVF;
    logic [7:0] OUT, TX_DATA;
    logic [4:0] RX_LEVEL, TX_LEVEL;

    logic       pRDY, pRDA, pRX_READY, pTX_VALID, pOVF;
    logic [7:0] pOUT, pTX_DATA;
    logic [4:0] pRX_LEVEL, pTX_LEVEL;

    int totalChecks = 0;
    int badChecks   = 0;

    // Reference model state
    logic [7:0] rxQ[$];
    logic [7:0] txQ[$];
    logic       mOvf;
    int         mPcnt;

    buffered_console dut (
        .CLK(CLK), .RESET(RESET), .IN(IN), .WR(WR), .RDY(RDY), .OUT(OUT),
        .RDA(RDA), .ACK(ACK), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RX_READY(RX_READY), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .TX_READY(TX_READY), .RX_LEVEL(RX_LEVEL), .TX_LEVEL(TX_LEVEL),
        .OVF(OVF), .CLR_OVF(CLR_OVF)
    );

    buffered_console #(.PATTERN_MODE(1)) dutPat (
        .CLK(CLK), .RESET(RESET), .IN(IN), .WR(WR), .RDY(pRDY), .OUT(pOUT),
        .RDA(pRDA), .ACK(ACK), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RX_READY(pRX_READY), .TX_DATA(pTX_DATA), .TX_VALID(pTX_VALID),
        .TX_READY(TX_READY), .RX_LEVEL(pRX_LEVEL), .TX_LEVEL(pTX_LEVEL),
        .OVF(pOVF), .CLR_OVF(CLR_OVF)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advances the model by one rising edge using the inputs now applied.
    task automatic modelEdge();
        bit txFull, rxFull, txPop, rxPop;
        if (RESET) begin
            rxQ.delete();
            txQ.delete();
            mOvf  = 1'b0;
            mPcnt = 0;
        end else begin
            txFull = (txQ.size() == 16);
            rxFull = (rxQ.size() == 16);
            txPop  = TX_READY && (txQ.size() != 0);
            rxPop  = ACK && (rxQ.size() != 0);
            if (txPop) void'(txQ.pop_front());
            if (WR && !txFull) txQ.push_back(IN);
            if (rxPop) void'(rxQ.pop_front());
            if (RX_VALID && !rxFull) rxQ.push_back(RX_DATA);
            if (WR && txFull) mOvf = 1'b1;
            else if (CLR_OVF) mOvf = 1'b0;
            if (ACK) mPcnt = (mPcnt + 1) % 26;
        end
    endtask

    task automatic checkAll();
        logic [7:0] expOut, expTx, expPat;
        expOut = (rxQ.size() != 0) ? rxQ[0] : 8'h00;
        expTx  = (txQ.size() != 0) ? txQ[0] : 8'h00;
        expPat = 8'(8'h41 + mPcnt);
        checkOutput("RDY",      RDY,      (txQ.size() != 16));
        checkOutput("TX_VALID", TX_VALID, (txQ.size() != 0));
        checkOutput("TX_DATA",  TX_DATA,  expTx);
        checkOutput("TX_LEVEL", TX_LEVEL, txQ.size());
        checkOutput("RX_READY", RX_READY, (rxQ.size() != 16));
        checkOutput("RDA",      RDA,      (rxQ.size() != 0));
        checkOutput("OUT",      OUT,      expOut);
        checkOutput("RX_LEVEL", RX_LEVEL, rxQ.size());
        checkOutput("OVF",      OVF,      mOvf);
        checkOutput("pat_RDA",      pRDA,      1);
        checkOutput("pat_OUT",      pOUT,      expPat);
        checkOutput("pat_RX_READY", pRX_READY, 0);
        checkOutput("pat_RX_LEVEL", pRX_LEVEL, 0);
        checkOutput("pat_TX_LEVEL", pTX_LEVEL, txQ.size());
        checkOutput("pat_OVF",      pOVF,      mOvf);
    endtask

    // Applies one cycle of inputs, steps the model at the edge, then
    // compares everything half a cycle later.
    task automatic applyStimulus(input logic rst, input logic [7:0] inB, input logic wr,
                                 input logic ack, input logic [7:0] rxD, input logic rxV,
                                 input logic txR, input logic clr);
        RESET = rst; IN = inB; WR = wr; ACK = ack;
        RX_DATA = rxD; RX_VALID = rxV; TX_READY = txR; CLR_OVF = clr;
        @(posedge CLK);
        modelEdge();
        @(negedge CLK);
        checkAll();
    endtask

    task automatic idle();
        applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    endtask

    initial begin
        mOvf  = 1'b0;
        mPcnt = 0;
        applyStimulus(1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        applyStimulus(1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        checkOutput("reset_RDA", RDA, 0);
        checkOutput("reset_RDY", RDY, 1);
        checkOutput("reset_pat_OUT", pOUT, 8'h41);

        // Host streams 10..1F while the CPU acknowledges every cycle.
        for (int i = 0; i < 16; i++)
            applyStimulus(0, 8'h00, 0, 1, 8'(8'h10 + i), 1, 0, 0);
        applyStimulus(0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        checkOutput("stream_RX_LEVEL", RX_LEVEL, 0);
        checkOutput("stream_RDA", RDA, 0);

        // Fill TX past capacity with the host stalled.
        for (int i = 0; i < 17; i++)
            applyStimulus(0, 8'(8'hC0 + i), 1, 0, 8'h00, 0, 0, 0);
        checkOutput("fill_TX_LEVEL", TX_LEVEL, 16);
        checkOutput("fill_OVF", OVF, 1);
        checkOutput("fill_RDY", RDY, 0);
        applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
        checkOutput("clr_OVF", OVF, 0);

        // Write and host pop together on a full FIFO: pop only.
        applyStimulus(0, 8'hEE, 1, 0, 8'h00, 0, 1, 0);
        checkOutput("fullpop_TX_LEVEL", TX_LEVEL, 15);
        checkOutput("fullpop_OVF", OVF, 1);
        checkOutput("fullpop_TX_DATA", TX_DATA, 8'hC1);

        // Pattern source: reset, then 26 ACKs return to the base value.
        applyStimulus(1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 26; i++)
            applyStimulus(0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        checkOutput("pat_wrap", pOUT, 8'h41);
        applyStimulus(0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        checkOutput("pat_after_wrap", pOUT, 8'h42);

        // Reset with bytes buffered on RX discards them.
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 8'h00, 0, 0, 8'(8'h60 + i), 1, 0, 0);
        checkOutput("buf5_RX_LEVEL", RX_LEVEL, 5);
        applyStimulus(1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        checkOutput("rst_RX_LEVEL", RX_LEVEL, 0);
        applyStimulus(0, 8'h00, 0, 0, 8'hAA, 1, 0, 0);
        checkOutput("post_rst_OUT", OUT, 8'hAA);

        // Push and ACK into an empty RX: push only.
        applyStimulus(0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 1, 8'h55, 1, 0, 0);
        checkOutput("empty_ack_OUT", OUT, 8'h55);
        checkOutput("empty_ack_RX_LEVEL", RX_LEVEL, 1);
        idle();

        // Randomised traffic with different push/pop balances per phase.
        for (int phase = 0; phase < 4; phase++) begin
            for (int n = 0; n < 500; n++) begin
                int wrP, popP;
                wrP  = (phase == 0) ? 80 : (phase == 1) ? 20 : 50;
                popP = (phase == 0) ? 20 : (phase == 1) ? 80 : 50;
                applyStimulus(($urandom_range(0, 199) == 0),
                              8'($urandom),
                              ($urandom_range(0, 99) < wrP),
                              ($urandom_range(0, 99) < popP),
                              8'($urandom),
                              ($urandom_range(0, 99) < wrP),
                              ($urandom_range(0, 99) < popP),
                              ($urandom_range(0, 19) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule

// File: doc/buffered_console.md
BUFFERED_CONSOLE -- requirements
Module: buffered_console

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of every data path.
REQ-002 Parameter RX_AW, default 4: log2 of RX FIFO depth (host->CPU).
REQ-003 Parameter TX_AW, default 4: log2 of TX FIFO depth (CPU->host).
REQ-004 Parameter PATTERN_MODE, default 0: 1 = RX side replaced by internal pattern source.
REQ-005 Parameter PATTERN_BASE, default 8'h41: first pattern value.
REQ-006 Parameter PATTERN_LEN, default 26: pattern period, legal range 1..2^DATA_WIDTH.
REQ-007 CLK  in  1  clock; all state changes on rising edge.
REQ-008 RESET  in  1  reset, synchronous, active-high; clock CLK.
REQ-009 IN  in  DATA_WIDTH  byte written by CPU.
REQ-010 WR  in  1  CPU write strobe, one byte per cycle high.
REQ-011 RDY  out  1  TX FIFO can accept a byte.
REQ-012 OUT  out  DATA_WIDTH  byte offered to CPU.
REQ-013 RDA  out  1  OUT is valid.
REQ-014 ACK  in  1  CPU consumes OUT, one byte per cycle high.
REQ-015 RX_DATA / RX_VALID in, RX_READY out  DATA_WIDTH/1/1  host push port, valid/ready.
REQ-016 TX_DATA / TX_VALID out, TX_READY in  DATA_WIDTH/1/1  host pop port, valid/ready.
REQ-017 RX_LEVEL  out  RX_AW+1  RX occupancy; TX_LEVEL  out  TX_AW+1  TX occupancy.
REQ-018 OVF  out  1  sticky: CPU write dropped; CLR_OVF  in  1  clears OVF.

Function
REQ-019 Both FIFOs SHALL be first-word-fall-through: byte accepted at edge N appears on OUT/TX_DATA with RDA/TX_VALID high after edge N (1-cycle latency).
REQ-020 RDY = (TX_LEVEL != 2^TX_AW); RX_READY = (RX_LEVEL != 2^RX_AW) when PATTERN_MODE=0; all readies from registered state only.
REQ-021 RDA = (RX_LEVEL != 0); TX_VALID = (TX_LEVEL != 0); OUT and TX_DATA SHALL read 0 when their FIFO is empty.
REQ-022 Push occurs on WR&&RDY (TX) or RX_VALID&&RX_READY (RX); pop on ACK&&RDA (RX) or TX_VALID&&TX_READY (TX).
REQ-023 Simultaneous push and pop on one FIFO: both SHALL occur, level unchanged; on full, push refused (ready low), pop proceeds; on empty, pop ignored, push proceeds.
REQ-024 ACK while RDA=0 SHALL have no effect; TX_READY while TX_VALID=0 SHALL have no effect.
REQ-025 WR while RDY=0 SHALL drop the byte and set OVF at that edge; CLR_OVF clears OVF; simultaneous set and clear: set wins.
REQ-026 Read/write pointers SHALL wrap modulo depth; level arithmetic is RX_AW+1 / TX_AW+1 bits, never exceeding depth.
REQ-027 PATTERN_MODE=1: RDA=1 constantly, OUT = PATTERN_BASE + PCNT (truncated to DATA_WIDTH), RX_READY=0, RX_LEVEL=0, RX_DATA ignored.
REQ-028 PCNT SHALL increment on each ACK and wrap from PATTERN_LEN-1 to 0.
REQ-029 FIFO storage contents need not be reset; only pointers, levels, PCNT, OVF.

Reset
REQ-030 While RESET high at an edge: pointers, levels, PCNT cleared; OVF=0; all pushes/pops that cycle discarded.
REQ-031 After reset: RDA=0 (mode 0) or 1 with OUT=PATTERN_BASE (mode 1); TX_VALID=0; RDY=1; RX_READY=1 (mode 0); OUT=0, TX_DATA=0 (mode 0).
REQ-032 Reset mid-transfer SHALL discard all buffered bytes; first post-reset push behaves as into an empty FIFO.

Verification
REQ-033 Mode 0: host pushes 8'h10..8'h1F, CPU ACKs each cycle -> OUT sequence 10..1F, RX_LEVEL returns 0, RDA low after last.
REQ-034 Mode 0, TX_AW=4: CPU WR 17 bytes, TX_READY=0 -> RDY low after 16th, 17th dropped, OVF=1, TX_LEVEL=16; CLR_OVF -> OVF=0.
REQ-035 Full TX with WR and TX_READY same cycle -> pop occurs, WR dropped (RDY was low), TX_LEVEL=15, OVF=1.
REQ-036 Mode 1, defaults: 27 ACKs -> OUT = 41,42,...,5A,41; RDA never low.
REQ-037 RX with 5 bytes buffered, RESET one cycle -> RX_LEVEL=0, RDA=0; next push 8'hAA appears on OUT next cycle.
REQ-038 Empty RX, RX_VALID and ACK same cycle with 8'h55 -> no pop, OUT=8'h55, RX_LEVEL=1 next cycle.
